// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sound_pkg
//  Purpose  : Shared source IDs, request bit order and FSM states for the
//             sound arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package sound_pkg;

    localparam int REQ_W       = 4;

    // Bit positions within the req/grant vectors
    localparam int REQ_HORN    = 3;
    localparam int REQ_CLICK   = 2;
    localparam int REQ_REVERSE = 1;
    localparam int REQ_ENGINE  = 0;

    localparam logic [1:0] SRC_HORN    = 2'd3;
    localparam logic [1:0] SRC_CLICK   = 2'd2;
    localparam logic [1:0] SRC_REVERSE = 2'd1;
    localparam logic [1:0] SRC_ENGINE  = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Request bits with strictly higher priority than source id
    function automatic logic [REQ_W-1:0] higher_mask(input logic [1:0] id);
        logic [REQ_W-1:0] base;
        base        = 4'b1110;
        higher_mask = base << id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sound_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : sound_prio_enc
//  Purpose  : 4-bit fixed-priority encoder (horn > click > reverse > engine).
//  Revision : 1.0  initial release
// ============================================================================
module sound_prio_enc
    import sound_pkg::*;
(
    input  logic [REQ_W-1:0] req,
    output logic             valid,
    output logic [1:0]       id,
    output logic [REQ_W-1:0] onehot
);

    always_comb begin
        valid  = |req;
        id     = SRC_ENGINE;
        onehot = '0;
        if (req[REQ_HORN]) begin
            id               = SRC_HORN;
            onehot[REQ_HORN] = 1'b1;
        end else if (req[REQ_CLICK]) begin
            id                = SRC_CLICK;
            onehot[REQ_CLICK] = 1'b1;
        end else if (req[REQ_REVERSE]) begin
            id                  = SRC_REVERSE;
            onehot[REQ_REVERSE] = 1'b1;
        end else if (req[REQ_ENGINE]) begin
            id                 = SRC_ENGINE;
            onehot[REQ_ENGINE] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sound_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sound_arbiter
//  Purpose  : Fixed-priority sound source arbiter with minimum hold time,
//             horn preemption and a silent gap on every source switch.
//  Revision : 1.0  initial release
// ============================================================================
module sound_arbiter
    import sound_pkg::*;
#(
    parameter int MIN_HOLD = 2_500_000,
    parameter int GAP_CYC  = 250_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_W-1:0] req,
    output logic [REQ_W-1:0] grant,
    output logic [1:0]       sel,
    output logic             mute,
    output logic [7:0]       preempt_cnt
);

    localparam int c_hold_w   = $clog2(MIN_HOLD + 2);
    localparam int c_gap_w    = $clog2(GAP_CYC + 1);
    localparam int c_gap_last = GAP_CYC - 1;
    localparam logic [c_hold_w-1:0] c_hold_max = MIN_HOLD[c_hold_w-1:0];
    localparam logic [c_gap_w-1:0]  c_gap_end  = c_gap_last[c_gap_w-1:0];

    state_t              r_state, w_state_n;
    logic [REQ_W-1:0]    r_grant, w_grant_n;
    logic [1:0]          r_sel, w_sel_n;
    logic                r_mute, w_mute_n;
    logic [7:0]          r_preempt;
    logic [c_hold_w-1:0] r_hold, w_hold_n;
    logic [c_gap_w-1:0]  r_gap, w_gap_n;
    logic                w_preempt;

    logic                w_enc_valid;
    logic [1:0]          w_enc_id;
    logic [REQ_W-1:0]    w_enc_onehot;

    sound_prio_enc u_enc (
        .req    (req),
        .valid  (w_enc_valid),
        .id     (w_enc_id),
        .onehot (w_enc_onehot)
    );

    always_comb begin
        w_state_n = r_state;
        w_grant_n = r_grant;
        w_sel_n   = r_sel;
        w_mute_n  = r_mute;
        w_hold_n  = r_hold;
        w_gap_n   = r_gap;
        w_preempt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_enc_valid) begin
                    w_state_n = ST_PLAY;
                    w_grant_n = w_enc_onehot;
                    w_sel_n   = w_enc_id;
                    w_mute_n  = 1'b0;
                    w_hold_n  = '0;
                end
            end

            ST_PLAY: begin
                if (r_hold != c_hold_max) begin
                    w_hold_n = r_hold + 1'b1;
                end
                // Release wins over any simultaneous preemption request
                if (!req[r_sel]) begin
                    w_state_n = ST_GAP;
                end else if (req[REQ_HORN] && (r_sel != SRC_HORN)) begin
                    w_state_n = ST_GAP;
                    w_preempt = 1'b1;
                end else if ((|(req & higher_mask(r_sel))) && (r_hold == c_hold_max)) begin
                    w_state_n = ST_GAP;
                    w_preempt = 1'b1;
                end
                if (w_state_n == ST_GAP) begin
                    w_grant_n = '0;
                    w_sel_n   = SRC_ENGINE;
                    w_mute_n  = 1'b1;
                    w_hold_n  = '0;
                    w_gap_n   = '0;
                end
            end

            ST_GAP: begin
                if (r_gap == c_gap_end) begin
                    w_gap_n = '0;
                    if (w_enc_valid) begin
                        w_state_n = ST_PLAY;
                        w_grant_n = w_enc_onehot;
                        w_sel_n   = w_enc_id;
                        w_mute_n  = 1'b0;
                        w_hold_n  = '0;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end else begin
                    w_gap_n = r_gap + 1'b1;
                end
            end

            default: begin
                w_state_n = ST_IDLE;
                w_grant_n = '0;
                w_sel_n   = SRC_ENGINE;
                w_mute_n  = 1'b1;
                w_hold_n  = '0;
                w_gap_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_sel     <= SRC_ENGINE;
            r_mute    <= 1'b1;
            r_preempt <= 8'd0;
            r_hold    <= '0;
            r_gap     <= '0;
        end else begin
            r_state <= w_state_n;
            r_grant <= w_grant_n;
            r_sel   <= w_sel_n;
            r_mute  <= w_mute_n;
            r_hold  <= w_hold_n;
            r_gap   <= w_gap_n;
            if (w_preempt && (r_preempt != 8'hFF)) begin
                r_preempt <= r_preempt + 8'd1;
            end
        end
    end

    assign grant       = r_grant;
    assign sel         = r_sel;
    assign mute        = r_mute;
    assign preempt_cnt = r_preempt;

endmodule
`default_nettype wire
